// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter one frame at a time
// via a start/data/done handshake.
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic              busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic              r_overflow;
   logic              r_tx_start;
   logic [7:0]        r_tx_data;
   logic              w_push;
   logic              w_pop;
   assign full     = r_count == (ADDR_W+1)'(DEPTH);
   assign empty    = r_count == '0;
   assign busy     = r_state == S_WAIT;
   assign count    = r_count;
   assign overflow = r_overflow;
   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
   // full is the registered flag, so a write racing a pop on a full FIFO is still dropped
   assign w_push   = wr_en & ~full;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == S_IDLE) ? (empty ? S_IDLE : S_WAIT) :
               (r_state == S_WAIT) ? (tx_done ? S_IDLE : S_WAIT) : S_IDLE;
   end
   always_comb begin
      w_pop = (r_state == S_IDLE) && !empty;
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_tx_start <= 1'b0;
         r_tx_data  <= 8'h00;
      end else begin
         r_wr_ptr   <= r_wr_ptr + ADDR_W'(w_push);
         r_rd_ptr   <= r_rd_ptr + ADDR_W'(w_pop);
         r_count    <= r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
         r_overflow <= wr_en & full;
         r_tx_start <= w_pop;
         if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
      end
   end
endmodule
